// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the hazard unit.
//   REG_ADDR_W / REG_NUM : register address width and architectural register count
//   REG_ZERO             : x0, hard-wired zero, never a real dependency
//   hazard_cause_e       : why ID is being held (debug / assertion visibility)
//   md_state_e           : mul/div unit FSM state (debug visibility)
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 2 ** REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_LOADUSE,
        HZ_RAW,
        HZ_WAW,
        HZ_STRUCT
    } hazard_cause_e;

    // MD_WB is the single cycle in which the result is written back.
    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_WB
    } md_state_e;

    // True when a used, non-x0 source register names the given target.
    function automatic logic src_match(input logic used, input reg_addr_t src,
                                       input reg_addr_t tgt);
        return used && (src != REG_ZERO) && (src == tgt);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the ID/EX pipeline control and the hazard scoreboard.
//   master : pipeline side, drives the ID/EX instruction fields and Flush_i,
//            receives the stall/write-enable/bubble controls and mul/div writeback.
//   slave  : the hazard scoreboard itself.
//
// Hand-off rule: IDValid_i offers the instruction held in IF/ID. It is consumed
// (issues) at a rising edge where Stall_o=0 and Flush_i=0. While Stall_o=1 the
// pipeline keeps PC and IF/ID frozen (PCWrite_o/IFIDWrite_o low), so the ID
// fields stay stable until the edge that consumes them. Flush_i kills the offer
// unconditionally; there is no back-pressure on MDWbValid_o.
interface hazard_scoreboard_if;
    import cpu_pkg::*;

    logic      IDValid_i;
    reg_addr_t IDRs1_i;
    reg_addr_t IDRs2_i;
    logic      IDUseRs1_i;
    logic      IDUseRs2_i;
    reg_addr_t IDRd_i;
    logic      IDRegWrite_i;
    logic      IDIsMD_i;
    logic      EXMemRead_i;
    reg_addr_t EXRd_i;
    logic      Flush_i;

    logic      Stall_o;
    logic      PCWrite_o;
    logic      IFIDWrite_o;
    logic      Bubble_o;
    logic      MDBusy_o;
    logic      MDWbValid_o;
    reg_addr_t MDWbRd_o;

    modport master (
        output IDValid_i, IDRs1_i, IDRs2_i, IDUseRs1_i, IDUseRs2_i, IDRd_i,
               IDRegWrite_i, IDIsMD_i, EXMemRead_i, EXRd_i, Flush_i,
        input  Stall_o, PCWrite_o, IFIDWrite_o, Bubble_o, MDBusy_o,
               MDWbValid_o, MDWbRd_o
    );

    modport slave (
        input  IDValid_i, IDRs1_i, IDRs2_i, IDUseRs1_i, IDUseRs2_i, IDRd_i,
               IDRegWrite_i, IDIsMD_i, EXMemRead_i, EXRd_i, Flush_i,
        output Stall_o, PCWrite_o, IFIDWrite_o, Bubble_o, MDBusy_o,
               MDWbValid_o, MDWbRd_o
    );

endinterface

// File: rtl/md_latency_counter.sv
// Mul/div latency counter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load         : start a new operation, count := MD_LATENCY-1
//   dec          : count down by one (saturates at 0)
//   done         : the decrement taken this cycle is the final one; the next
//                  cycle is the writeback cycle
// MD_LATENCY must be in 2..15 so the load value fits 4 bits and is non-zero.
module md_latency_counter #(
    parameter int MD_LATENCY = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam logic [3:0] LOAD_VAL = 4'(MD_LATENCY - 1);

    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign done = dec && (cnt_q == 4'd1);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: holds the pipeline for hazards that EX forwarding
// cannot cover (load-use, and RAW/WAW/structural against the one in-flight
// mul/div op), owns the mul/div latency counter and pending-register record,
// and emits the mul/div writeback strobe.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   bus           : hazard_scoreboard_if.slave (ID/EX fields in, controls out)
//   hazard_cause  : reason for the current stall, HZ_NONE when not stalling
//   md_state      : mul/div FSM state
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hazard_scoreboard_if.slave    bus,
    output hazard_cause_e         hazard_cause,
    output md_state_e             md_state
);

    md_state_e state_q, state_d;

    // Only one mul/div can be in flight, so the pending scoreboard collapses
    // to a single valid bit plus the destination it guards.
    logic      pend_valid_q;
    reg_addr_t md_rd_q;

    logic md_busy, md_wb;
    logic cnt_load, cnt_dec, cnt_done;
    logic load_use, raw, waw, structural;
    logic stall, issue, md_issue;

    // ---------------- hazard comparators ----------------
    assign load_use = bus.EXMemRead_i &&
                      (src_match(bus.IDUseRs1_i, bus.IDRs1_i, bus.EXRd_i) ||
                       src_match(bus.IDUseRs2_i, bus.IDRs2_i, bus.EXRd_i));

    assign raw = pend_valid_q &&
                 (src_match(bus.IDUseRs1_i, bus.IDRs1_i, md_rd_q) ||
                  src_match(bus.IDUseRs2_i, bus.IDRs2_i, md_rd_q));

    assign waw = pend_valid_q &&
                 src_match(bus.IDRegWrite_i, bus.IDRd_i, md_rd_q);

    // Also covers an MD op arriving during the writeback cycle, so a new
    // issue never coincides with completion.
    assign structural = bus.IDIsMD_i && md_busy;

    // Flush wins: the instruction in ID is being killed, nothing to hold.
    assign stall    = bus.IDValid_i && !bus.Flush_i &&
                      (load_use || raw || waw || structural);
    assign issue    = bus.IDValid_i && !stall && !bus.Flush_i;
    assign md_issue = issue && bus.IDIsMD_i;

    always_comb begin
        hazard_cause = HZ_NONE;
        if (bus.IDValid_i && !bus.Flush_i) begin
            if (load_use)        hazard_cause = HZ_LOADUSE;
            else if (raw)        hazard_cause = HZ_RAW;
            else if (waw)        hazard_cause = HZ_WAW;
            else if (structural) hazard_cause = HZ_STRUCT;
        end
    end

    // ---------------- mul/div FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (md_issue) state_d = MD_BUSY;
            MD_BUSY: if (cnt_done) state_d = MD_WB;
            MD_WB:   state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        md_busy = 1'b0;
        md_wb   = 1'b0;
        cnt_dec = 1'b0;
        case (state_q)
            MD_BUSY: begin
                md_busy = 1'b1;
                cnt_dec = 1'b1;
            end
            MD_WB: begin
                md_busy = 1'b1;
                md_wb   = 1'b1;
            end
            default: ;
        endcase
    end

    // md_issue can only be true in MD_IDLE (structural hazard otherwise).
    assign cnt_load = md_issue;

    md_latency_counter #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .done  (cnt_done)
    );

    // ---------------- pending record ----------------
    // rd is latched even for x0 / no-write ops so MDWbRd_o always reflects the
    // op that is writing back; only the pending bit is suppressed for them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_valid_q <= 1'b0;
            md_rd_q      <= REG_ZERO;
        end else if (md_issue) begin
            pend_valid_q <= bus.IDRegWrite_i && (bus.IDRd_i != REG_ZERO);
            md_rd_q      <= bus.IDRd_i;
        end else if (md_wb) begin
            pend_valid_q <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign bus.Stall_o     = stall;
    assign bus.PCWrite_o   = !stall;
    assign bus.IFIDWrite_o = !stall;
    assign bus.Bubble_o    = stall || bus.Flush_i;
    assign bus.MDBusy_o    = md_busy;
    assign bus.MDWbValid_o = md_wb;
    assign bus.MDWbRd_o    = md_rd_q;

    assign md_state = state_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import cpu_pkg::*;

    localparam int L = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    hazard_cause_e hazard_cause;
    md_state_e     md_state;

    hazard_scoreboard_if bus();

    hazard_scoreboard #(
        .MD_LATENCY(L)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .hazard_cause (hazard_cause),
        .md_state     (md_state)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: time-based view of the single mul/div op.
    // md_end is the cycle number of its writeback cycle (-1: none).
    int        cyc     = 0;
    int        md_end  = -1;
    logic [4:0] md_rd  = '0;
    bit        md_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        md_end  = -1;
        md_pend = 1'b0;
        md_rd   = '0;
    endfunction

    function automatic bit m_busy();
        return cyc <= md_end;
    endfunction

    function automatic bit uses(input logic u, input logic [4:0] src, input logic [4:0] r);
        return u && (src != 5'd0) && (src == r);
    endfunction

    function automatic bit m_stall();
        bit pend, lu, raw, waw, st;
        pend = md_pend && m_busy();
        lu   = bus.EXMemRead_i &&
               (uses(bus.IDUseRs1_i, bus.IDRs1_i, bus.EXRd_i) ||
                uses(bus.IDUseRs2_i, bus.IDRs2_i, bus.EXRd_i));
        raw  = pend && (uses(bus.IDUseRs1_i, bus.IDRs1_i, md_rd) ||
                        uses(bus.IDUseRs2_i, bus.IDRs2_i, md_rd));
        waw  = pend && uses(bus.IDRegWrite_i, bus.IDRd_i, md_rd);
        st   = bus.IDIsMD_i && m_busy();
        return bus.IDValid_i && !bus.Flush_i && (lu || raw || waw || st);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                          input bit u2, input int rd, input bit rw, input bit md);
        bus.IDValid_i    = v;
        bus.IDRs1_i      = 5'(rs1);
        bus.IDUseRs1_i   = u1;
        bus.IDRs2_i      = 5'(rs2);
        bus.IDUseRs2_i   = u2;
        bus.IDRd_i       = 5'(rd);
        bus.IDRegWrite_i = rw;
        bus.IDIsMD_i     = md;
    endtask

    task automatic set_ex(input bit mr, input int rd);
        bus.EXMemRead_i = mr;
        bus.EXRd_i      = 5'(rd);
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ex(0, 0);
        bus.Flush_i = 1'b0;
    endtask

    // Check every output mid-cycle, then advance the model at the edge.
    task automatic tick(input string tag);
        bit es, ewb;
        @(negedge clk_i);
        if (rst_i) m_reset();
        es  = m_stall();
        ewb = (cyc == md_end);
        chk({tag, ":stall"},   bus.Stall_o,     es);
        chk({tag, ":pcwr"},    bus.PCWrite_o,   !es);
        chk({tag, ":ifidwr"},  bus.IFIDWrite_o, !es);
        chk({tag, ":bubble"},  bus.Bubble_o,    es || bus.Flush_i);
        chk({tag, ":busy"},    bus.MDBusy_o,    m_busy());
        chk({tag, ":wbvalid"}, bus.MDWbValid_o, ewb);
        if (ewb) chk({tag, ":wbrd"}, bus.MDWbRd_o, md_rd);
        chk({tag, ":cause"},   hazard_cause != HZ_NONE, es);
        @(posedge clk_i);
        if (rst_i) begin
            m_reset();
        end else if (bus.IDValid_i && !es && !bus.Flush_i && bus.IDIsMD_i) begin
            md_end  = cyc + L;
            md_rd   = bus.IDRd_i;
            md_pend = bus.IDRegWrite_i && (bus.IDRd_i != 5'd0);
        end
        cyc++;
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_i = 1'b1;
        idle();
        tick("rst0");
        tick("rst1");
        chk("rst_wbrd", bus.MDWbRd_o, 0);
        rst_i = 1'b0;
        tick("idle");

        // Load-use on rs1: one stall cycle, then the load has left EX.
        set_ex(1, 5); set_id(1, 5, 1, 1, 1, 6, 1, 0);
        tick("lu_rs1");
        set_ex(0, 0);
        tick("lu_rs1_issue");
        // EXRd=x0 with an x0 source: never a hazard.
        set_ex(1, 0); set_id(1, 0, 1, 1, 1, 6, 1, 0);
        tick("lu_x0");
        // Load-use via rs2, then same regs with rs2 unused.
        set_ex(1, 3); set_id(1, 1, 1, 3, 1, 4, 1, 0);
        tick("lu_rs2");
        set_id(1, 1, 1, 3, 0, 4, 1, 0);
        tick("lu_rs2_unused");
        idle();
        tick("idle2");

        // mul x7 then dependent add x8,x7,x2: stalls T+1..T+4, issues T+5.
        set_id(1, 1, 1, 2, 1, 7, 1, 1);
        tick("mul7");
        set_id(1, 7, 1, 2, 1, 8, 1, 0);
        repeat (L + 1) tick("raw_x7");
        idle();
        tick("idle3");

        // mul x7 then independent op (rs1=x3, rs2=x7 unused).
        set_id(1, 1, 1, 2, 1, 7, 1, 1);
        tick("mul7b");
        set_id(1, 3, 1, 7, 0, 8, 1, 0);
        tick("noraw");
        idle();
        repeat (L) tick("drain1");

        // Back-to-back mul x7, div x9: structural stall, div writes back at T+9.
        set_id(1, 1, 1, 2, 1, 7, 1, 1);
        tick("mul7c");
        set_id(1, 3, 1, 4, 1, 9, 1, 1);
        repeat (L + 1) tick("div_struct");
        idle();
        repeat (L + 1) tick("div_drain");

        // WAW: addi x7 while mul x7 pending.
        set_id(1, 1, 1, 2, 1, 7, 1, 1);
        tick("mul7d");
        set_id(1, 1, 1, 0, 0, 7, 1, 0);
        repeat (L + 1) tick("waw");
        idle();
        tick("idle4");

        // mul x0: no pending bit, x0 reader never stalls, strobe still fires.
        set_id(1, 1, 1, 2, 1, 0, 1, 1);
        tick("mul0");
        set_id(1, 0, 1, 0, 1, 3, 1, 0);
        tick("read_x0");
        idle();
        repeat (L) tick("mul0_drain");

        // Async reset in cycle T+2 of a mul: immediate clear, no strobe later.
        set_id(1, 1, 1, 2, 1, 7, 1, 1);
        tick("mul7e");
        idle();
        tick("mul7e_t1");
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_busy",   bus.MDBusy_o,    0);
        chk("async_rst_wb",     bus.MDWbValid_o, 0);
        chk("async_rst_wbrd",   bus.MDWbRd_o,    0);
        chk("async_rst_state",  md_state == MD_IDLE, 1);
        tick("rst_mid");
        rst_i = 1'b0;
        set_id(1, 7, 1, 7, 1, 8, 1, 0);
        repeat (L) tick("after_rst");
        idle();

        // Flush with a RAW hazard present: no stall, bubble still inserted.
        set_id(1, 1, 1, 2, 1, 7, 1, 1);
        tick("mul7f");
        set_id(1, 7, 1, 2, 1, 8, 1, 0);
        bus.Flush_i = 1'b1;
        tick("flush_raw");
        bus.Flush_i = 1'b0;
        tick("raw_after_flush");
        idle();
        repeat (L) tick("drain2");

        // Random traffic over a small register window to provoke collisions.
        repeat (400) begin
            set_id($urandom_range(3, 0) != 0,
                   $urandom_range(7, 0), $urandom_range(1, 0),
                   $urandom_range(7, 0), $urandom_range(1, 0),
                   $urandom_range(7, 0), $urandom_range(1, 0),
                   $urandom_range(3, 0) == 0);
            set_ex($urandom_range(2, 0) == 0, $urandom_range(7, 0));
            bus.Flush_i = ($urandom_range(9, 0) == 0);
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
